// File: rtl/servo_seq_ctrl.sv
// -----------------------------------------------------------------------------
// servo_seq_ctrl
//
// Plays a stored motion program into the servo PWM generator. Each step word
// in the step RAM is {dwell[4:0], position[7:0]}. For every step the sequencer
// fetches the word, hands the position to the PWM block over a valid/ready
// handshake, waits dwell * TICK_DIV clocks, then moves to the next step. A
// dwell field of zero marks the end of the program.
//
// Optional feature macro: SERVO_SEQ_RAMP_EN
//   Defined   : pos_out slews 1 LSB per tick toward each step's target. Every
//               tick issues one handshake. The dwell count starts once the
//               target is reached.
//   Undefined : the target position is issued in a single handshake.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   start      one-cycle pulse, begins a program (ignored unless idle)
//   stop       one-cycle pulse, aborts a running program
//   loop_en    restart at step 0 after the last step (sampled on start)
//   seq_base   first step RAM address (sampled on start)
//   seq_len    number of steps, 0 means 2^ADDR_LEN (sampled on start)
//   ram_addr   step RAM read address
//   ram_rd     read strobe, ram_data is valid one cycle later
//   ram_data   step word from the RAM
//   pos_out    position to the PWM generator
//   pos_valid  pos_out is valid
//   pos_ready  PWM generator accepts pos_out
//   busy       program running
//   done       one-cycle pulse at program end or stop
//   step_idx   current step index, 0-based
// -----------------------------------------------------------------------------
module servo_seq_ctrl #(
  parameter int CLK_FREQUENCY     = 50000000,
  parameter int TICK_DIV          = 500000,
  parameter int ADDR_LEN          = 8,
  parameter int POSITION_DATA_LEN = 8,
  parameter int SPEED_DATA_LEN    = 5,
  parameter int DATA_LEN          = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop_en,
  input  logic [ADDR_LEN-1:0]          seq_base,
  input  logic [ADDR_LEN-1:0]          seq_len,
  output logic [ADDR_LEN-1:0]          ram_addr,
  output logic                         ram_rd,
  input  logic [DATA_LEN-1:0]          ram_data,
  output logic [POSITION_DATA_LEN-1:0] pos_out,
  output logic                         pos_valid,
  input  logic                         pos_ready,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_LEN-1:0]          step_idx
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  // Reject configurations the word layout or tick counter cannot represent.
  if (CLK_FREQUENCY < 1 || TICK_DIV < 1 ||
      DATA_LEN != POSITION_DATA_LEN + SPEED_DATA_LEN) begin : g_bad_cfg
    $error("servo_seq_ctrl: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_RDWAIT = 3'd2,
    S_ISSUE  = 3'd3,
    S_DWELL  = 3'd4,
    S_DONE   = 3'd5,
    S_SLEW   = 3'd6
  } state_t;

  state_t                         state_q;
  logic [ADDR_LEN-1:0]            seq_base_q;
  logic [ADDR_LEN-1:0]            seq_len_q;
  logic                           loop_q;
  logic [ADDR_LEN-1:0]            step_idx_q;
  logic [ADDR_LEN-1:0]            ram_addr_q;
  logic                           ram_rd_q;
  logic [POSITION_DATA_LEN-1:0]   pos_out_q;
  logic                           pos_valid_q;
  logic                           busy_q;
  logic                           done_q;
  logic [TICK_W-1:0]              tick_q;
  logic [SPEED_DATA_LEN-1:0]      dwell_q;
`ifdef SERVO_SEQ_RAMP_EN
  logic [POSITION_DATA_LEN-1:0]   target_q;

  // One LSB toward the target; callers guarantee cur != tgt.
  function automatic logic [POSITION_DATA_LEN-1:0] slew_step(
    input logic [POSITION_DATA_LEN-1:0] cur,
    input logic [POSITION_DATA_LEN-1:0] tgt
  );
    if (tgt > cur) begin
      slew_step = cur + POSITION_DATA_LEN'(1);
    end else begin
      slew_step = cur - POSITION_DATA_LEN'(1);
    end
  endfunction
`endif

  logic [ADDR_LEN-1:0]          step_inc_d;
  logic                         last_step_s;
  logic                         tick_wrap_s;
  logic [SPEED_DATA_LEN-1:0]    rd_dwell_s;
  logic [POSITION_DATA_LEN-1:0] rd_pos_s;

  // Modulo compare makes seq_len == 0 behave as a full 2^ADDR_LEN program.
  assign step_inc_d  = step_idx_q + ADDR_LEN'(1);
  assign last_step_s = (step_inc_d == seq_len_q);
  assign tick_wrap_s = (tick_q == TICK_MAX);
  assign rd_dwell_s  = ram_data[POSITION_DATA_LEN +: SPEED_DATA_LEN];
  assign rd_pos_s    = ram_data[POSITION_DATA_LEN-1:0];

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      seq_base_q  <= '0;
      seq_len_q   <= '0;
      loop_q      <= 1'b0;
      step_idx_q  <= '0;
      ram_addr_q  <= '0;
      ram_rd_q    <= 1'b0;
      pos_out_q   <= '0;
      pos_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tick_q      <= '0;
      dwell_q     <= '0;
`ifdef SERVO_SEQ_RAMP_EN
      target_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            seq_base_q <= seq_base;
            seq_len_q  <= seq_len;
            loop_q     <= loop_en;
            step_idx_q <= '0;
            busy_q     <= 1'b1;
            ram_addr_q <= seq_base;
            ram_rd_q   <= 1'b1;
            state_q    <= S_FETCH;
          end
        end

        // ram_rd is already high for this cycle; the word arrives in RDWAIT.
        S_FETCH: begin
          ram_rd_q <= 1'b0;
          state_q  <= S_RDWAIT;
        end

        S_RDWAIT: begin
          if (rd_dwell_s == '0) begin
            // End marker: finish without issuing anything.
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            tick_q  <= '0;
            dwell_q <= '0;
            state_q <= S_DONE;
          end else begin
            dwell_q <= rd_dwell_s;
            tick_q  <= '0;
`ifdef SERVO_SEQ_RAMP_EN
            target_q <= rd_pos_s;
            if (rd_pos_s == pos_out_q) begin
              state_q <= S_DWELL;
            end else begin
              pos_out_q   <= slew_step(pos_out_q, rd_pos_s);
              pos_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
`else
            pos_out_q   <= rd_pos_s;
            pos_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
`endif
          end
        end

        S_ISSUE: begin
          if (pos_ready) begin
            pos_valid_q <= 1'b0;
            tick_q      <= '0;
`ifdef SERVO_SEQ_RAMP_EN
            state_q     <= (pos_out_q == target_q) ? S_DWELL : S_SLEW;
`else
            state_q     <= S_DWELL;
`endif
          end
        end

`ifdef SERVO_SEQ_RAMP_EN
        // Wait one tick between slew handshakes.
        S_SLEW: begin
          if (tick_wrap_s) begin
            tick_q      <= '0;
            pos_out_q   <= slew_step(pos_out_q, target_q);
            pos_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
`endif

        // Dwell lasts dwell * TICK_DIV cycles; the last cycle launches FETCH.
        S_DWELL: begin
          if (tick_wrap_s) begin
            tick_q <= '0;
            if (dwell_q == SPEED_DATA_LEN'(1)) begin
              dwell_q <= '0;
              if (last_step_s && !loop_q) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else if (last_step_s) begin
                step_idx_q <= '0;
                ram_addr_q <= seq_base_q;
                ram_rd_q   <= 1'b1;
                state_q    <= S_FETCH;
              end else begin
                step_idx_q <= step_inc_d;
                ram_addr_q <= seq_base_q + step_inc_d;
                ram_rd_q   <= 1'b1;
                state_q    <= S_FETCH;
              end
            end else begin
              dwell_q <= dwell_q - SPEED_DATA_LEN'(1);
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          ram_rd_q    <= 1'b0;
          pos_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase

      // Abort overrides whatever the state logic chose this cycle. DONE is
      // already on its way out, so a stop there leaves the pulse single.
      if (stop && (state_q != S_IDLE) && (state_q != S_DONE)) begin
        state_q     <= S_DONE;
        done_q      <= 1'b1;
        busy_q      <= 1'b0;
        pos_valid_q <= 1'b0;
        ram_rd_q    <= 1'b0;
        tick_q      <= '0;
        dwell_q     <= '0;
      end
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_rd    = ram_rd_q;
  assign pos_out   = pos_out_q;
  assign pos_valid = pos_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step_idx  = step_idx_q;

endmodule

// File: tb/tb_servo_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_servo_seq_ctrl
//
// Self-checking bench for servo_seq_ctrl with TICK_DIV = 4. A step-level
// reference model expands each program (base, length, loop) into the list of
// steps it must play; a monitor compares fetch addresses, issue timing,
// handshake contents, dwell spacing and done timing against that list.
// -----------------------------------------------------------------------------
module tb_servo_seq_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        pos_ready = 1'b0;
  logic [7:0]  seq_base = 8'h00;
  logic [7:0]  seq_len = 8'h00;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic [12:0] ram_data = 13'h0000;
  logic [7:0]  pos_out;
  logic        pos_valid;
  logic        busy;
  logic        done;
  logic [7:0]  step_idx;

  logic [12:0] mem [256];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  servo_seq_ctrl #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .seq_base  (seq_base),
    .seq_len   (seq_len),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_data  (ram_data),
    .pos_out   (pos_out),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .busy      (busy),
    .done      (done),
    .step_idx  (step_idx)
  );

  always #5 clk = ~clk;

  // Cycle counter and synchronous step RAM (one-cycle read latency).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd) ram_data <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] addr;
    logic [7:0] pos;
    int         dw;
    logic [7:0] idx;
  } step_t;

  step_t exp_q[$];
  int    end_idx;

  // Expand a program into the steps it plays: index i of k-th step is k, or
  // k mod len when looping; a zero dwell terminates the list.
  task automatic build_model(input logic [7:0] base, input int len, input bit lp, input int max_steps);
    step_t rec;
    exp_q.delete();
    end_idx = -1;
    for (int k = 0; k < max_steps; k++) begin
      int i;
      if (!lp && k >= len) break;
      i = lp ? (k % len) : k;
      rec.addr = 8'(int'(base) + i);
      rec.dw   = int'(mem[rec.addr][12:8]);
      rec.pos  = mem[rec.addr][7:0];
      rec.idx  = 8'(i);
      exp_q.push_back(rec);
      if (rec.dw == 0) begin
        end_idx = i;
        break;
      end
    end
  endtask

  // ---------------- monitor ----------------
  bit    mon_en = 1'b0;
  step_t cur;
  int    next_fetch, exp_done, fetch_cyc, n_acc, done_seen;
  bit    prev_valid, acc_last;
  logic [7:0] last_pos;

  // Compare observed behaviour against the expected step list each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (acc_last) check_eq("valid_drop", pos_valid, 1'b0);
      acc_last = 1'b0;
      if (ram_rd) begin
        check_eq("fetch_time", cyc, next_fetch);
        check_eq("fetch_pending", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check_eq("fetch_addr", ram_addr, cur.addr);
          fetch_cyc = cyc;
          if (cur.dw == 0) exp_done = cyc + 2;
        end
      end
      if (pos_valid) begin
        if (!prev_valid) begin
          check_eq("valid_time", cyc, fetch_cyc + 2);
          check_eq("valid_is_step", (cur.dw != 0), 1'b1);
        end
        check_eq("pos_stable", pos_out, cur.pos);
        if (pos_ready) begin
          check_eq("accept_idx", step_idx, cur.idx);
          n_acc++;
          last_pos = cur.pos;
          acc_last = 1'b1;
          if (exp_q.size() == 0) exp_done = cyc + cur.dw * TD + 1;
          else next_fetch = cyc + cur.dw * TD + 1;
        end
      end
      if (done) begin
        check_eq("done_time", cyc, exp_done);
        check_eq("done_busy", busy, 1'b0);
        done_seen = 1;
      end
      prev_valid = pos_valid;
    end
  end

  // Start a program and follow it to completion (or to a stop after
  // stop_after accepted handshakes). pct is the pos_ready probability.
  task automatic run_prog(input logic [7:0] base, input logic [7:0] len, input bit lp,
                          input int pct, input int stop_after);
    int fin = 0;
    build_model(base, (len == 8'd0) ? 256 : int'(len), lp, lp ? 8 : 256);
    @(posedge clk); #1;
    seq_base = base; seq_len = len; loop_en = lp; start = 1'b1;
    pos_ready = ($urandom_range(99) < pct);
    next_fetch = cyc + 1; n_acc = 0; done_seen = 0; exp_done = -1;
    prev_valid = 1'b0; acc_last = 1'b0; mon_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      // A second start while running must not disturb the program.
      start = (k == 2);
      seq_base = (k == 2) ? base + 8'h40 : base;
      pos_ready = ($urandom_range(99) < pct);
      if (done_seen != 0) begin fin = 1; break; end
      if (stop_after > 0 && n_acc >= stop_after) begin fin = 1; break; end
    end
    mon_en = 1'b0; start = 1'b0; seq_base = base;
    check_eq("prog_finish", fin, 1);
    if (stop_after > 0) begin
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      check_eq("stop_done", done, 1'b1);
      check_eq("stop_valid", pos_valid, 1'b0);
      check_eq("stop_busy", busy, 1'b0);
      @(posedge clk); #1;
    end else begin
      check_eq("end_busy", busy, 1'b0);
      check_eq("steps_left", exp_q.size(), 0);
      if (n_acc > 0) check_eq("pos_hold", pos_out, last_pos);
      if (end_idx >= 0) check_eq("marker_idx", step_idx, end_idx);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {5'd1, 8'(i)};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_vals", {ram_addr, ram_rd, pos_out, pos_valid, busy, done, step_idx}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic program, always ready
    mem[8'h10] = {5'd2, 8'h40};
    mem[8'h11] = {5'd1, 8'hC0};
    run_prog(8'h10, 8'd2, 1'b0, 100, 0);

    // Same program under heavy backpressure
    run_prog(8'h10, 8'd2, 1'b0, 20, 0);

    // End marker at step 1
    mem[8'h30] = {5'd2, 8'h55};
    mem[8'h31] = {5'd0, 8'h77};
    mem[8'h32] = {5'd1, 8'h88};
    mem[8'h33] = {5'd1, 8'h99};
    run_prog(8'h30, 8'd4, 1'b0, 100, 0);

    // Looping across the address wrap, then stopped
    mem[8'hFF] = {5'd1, 8'h21};
    mem[8'h00] = {5'd2, 8'hE0};
    run_prog(8'hFF, 8'd2, 1'b1, 70, 5);

    // Randomized programs, some with markers, some looping + stopped
    for (int r = 0; r < 8; r++) begin
      logic [7:0] b;
      int         l;
      bit         lp;
      b  = 8'($urandom);
      l  = $urandom_range(1, 4);
      lp = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < l; i++)
        mem[8'(int'(b) + i)] = {5'($urandom_range(1, 3)), 8'($urandom)};
      if (!lp && l > 1 && $urandom_range(0, 2) == 0)
        mem[8'(int'(b) + $urandom_range(1, l - 1))][12:8] = 5'd0;
      run_prog(b, 8'(l), lp, $urandom_range(25, 100), lp ? 3 : 0);
    end

    // Asynchronous reset in the middle of a dwell
    mem[8'h50] = {5'd3, 8'h9A};
    @(posedge clk); #1;
    seq_base = 8'h50; seq_len = 8'd1; loop_en = 1'b0; start = 1'b1; pos_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check_eq("busy_pre_rst", busy, 1'b1);
    check_eq("pos_pre_rst", pos_out, 8'h9A);
    rst = 1'b0;
    #1;
    check_eq("rst_async", {ram_addr, ram_rd, pos_out, pos_valid, busy, done, step_idx}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_prog(8'h10, 8'd2, 1'b0, 100, 0);

    // start and stop together while idle: start wins; then stop in FETCH
    @(posedge clk); #1;
    seq_base = 8'h10; seq_len = 8'd2; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check_eq("start_wins_busy", busy, 1'b1);
    check_eq("start_wins_rd", ram_rd, 1'b1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check_eq("stop_fetch_done", done, 1'b1);
    check_eq("stop_fetch_busy", busy, 1'b0);
    @(posedge clk); #1;
    check_eq("done_single", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
